// File: rtl/pc_pkg.sv
// Shared types for the PC sequencer: FSM states and redirect kinds.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } pc_state_e;

  typedef enum logic [2:0] {
    NONE,
    EXC,
    RET,
    CALL,
    JUMP,
    BRANCH
  } redir_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
module pc_ras #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [PC_W-1:0] i_push_data,
  output logic [PC_W-1:0] o_top,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_overflow,
  output logic            o_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;
  logic [CNT_W-1:0] count;

  // sp points at the next free slot, so the top lives one below it.
  assign o_top   = mem[sp - PTR_W'(1)];
  assign o_empty = (count == '0);
  assign o_full  = (count == CNT_W'(RAS_DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) begin
      mem[sp] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sp          <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      if (i_flush) begin
        count <= '0;
      end else if (i_push) begin
        sp <= sp + PTR_W'(1);
        if (o_full) begin
          o_overflow <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end else if (i_pop) begin
        if (o_empty) begin
          o_underflow <= 1'b1;
        end else begin
          sp    <= sp - PTR_W'(1);
          count <= count - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALT control, prioritised redirects and a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int unsigned     INC       = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] EXC_VEC   = 'h0080,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_fetch_ready,
  output logic            o_fetch_valid,
  output logic [PC_W-1:0] o_pc,
  input  logic            i_branch,
  input  logic            i_jump,
  input  logic            i_call,
  input  logic [PC_W-1:0] i_target,
  input  logic            i_ret,
  input  logic [PC_W-1:0] i_ret_fallback,
  input  logic            i_exc,
  input  logic            i_halt,
  input  logic            i_resume,
  output logic            o_ras_empty,
  output logic            o_ras_full,
  output logic            o_ras_overflow,
  output logic            o_ras_underflow
);

  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

  pc_state_e       state;
  redir_e          redir;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redir_target;
  logic [PC_W-1:0] ras_top;

  assign pc_inc = o_pc + INC_V;

  // Only an exception is honoured outside RUN; the rest obey fixed priority.
  always_comb begin
    redir = NONE;
    if (i_exc) begin
      redir = EXC;
    end else if (state == RUN) begin
      if (i_ret)         redir = RET;
      else if (i_call)   redir = CALL;
      else if (i_jump)   redir = JUMP;
      else if (i_branch) redir = BRANCH;
    end
  end

  always_comb begin
    redir_target = pc_inc;
    case (redir)
      EXC:                 redir_target = EXC_VEC;
      RET:                 redir_target = o_ras_empty ? i_ret_fallback : ras_top;
      CALL, JUMP, BRANCH:  redir_target = i_target;
      default:             redir_target = pc_inc;
    endcase
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (redir == CALL),
    .i_pop       (redir == RET),
    .i_flush     (redir == EXC),
    .i_push_data (pc_inc),
    .o_top       (ras_top),
    .o_empty     (o_ras_empty),
    .o_full      (o_ras_full),
    .o_overflow  (o_ras_overflow),
    .o_underflow (o_ras_underflow)
  );

  // A redirect cancels the current fetch and wins over halt and fetch-ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= BOOT;
      o_pc          <= RESET_VEC;
      o_fetch_valid <= 1'b0;
    end else if (redir != NONE) begin
      state         <= RUN;
      o_pc          <= redir_target;
      o_fetch_valid <= 1'b1;
    end else begin
      case (state)
        BOOT: begin
          state         <= RUN;
          o_fetch_valid <= 1'b1;
        end
        RUN: begin
          if (o_fetch_valid && i_fetch_ready) begin
            o_pc <= pc_inc;
          end
          if (i_halt) begin
            state         <= HALT;
            o_fetch_valid <= 1'b0;
          end
        end
        HALT: begin
          if (i_resume) begin
            state         <= RUN;
            o_fetch_valid <= 1'b1;
          end
        end
        default: begin
          state         <= BOOT;
          o_fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock, i_clk; reset i_rst_n SHALL be asynchronous and active-low.
REQ-002 Parameter PC_W, default 16: PC width in bits.
REQ-003 Parameter INC, default 4: sequential increment in bytes.
REQ-004 Parameter RESET_VEC, default 0: PC value loaded by reset.
REQ-005 Parameter EXC_VEC, default 'h0080: exception target.
REQ-006 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of 2, minimum 2.
REQ-007 Port i_clk, input, 1: clock.
REQ-008 Port i_rst_n, input, 1: async active-low reset.
REQ-009 Port i_fetch_ready, input, 1: instruction memory accepts the current PC.
REQ-010 Port o_fetch_valid, output, 1: o_pc is a valid fetch request.
REQ-011 Port o_pc, output, PC_W: current fetch PC.
REQ-012 Port i_branch, input, 1: taken conditional branch.
REQ-013 Port i_jump, input, 1: unconditional jump.
REQ-014 Port i_call, input, 1: jump-and-link.
REQ-015 Port i_target, input, PC_W: target for branch, jump or call.
REQ-016 Port i_ret, input, 1: return.
REQ-017 Port i_ret_fallback, input, PC_W: target used when the RAS is empty.
REQ-018 Port i_exc, input, 1: exception.
REQ-019 Port i_halt, input, 1: enter HALT.
REQ-020 Port i_resume, input, 1: leave HALT.
REQ-021 Port o_ras_empty, output, 1: RAS count is 0.
REQ-022 Port o_ras_full, output, 1: RAS count equals RAS_DEPTH.
REQ-023 Port o_ras_overflow, output, 1: one-cycle pulse, a call overwrote the oldest entry.
REQ-024 Port o_ras_underflow, output, 1: one-cycle pulse, a return found the RAS empty.

Function
REQ-025 The FSM SHALL have three states: BOOT, RUN and HALT.
REQ-026 BOOT SHALL hold o_fetch_valid=0 for exactly one cycle after reset release, then move to RUN.
REQ-027 In RUN, o_fetch_valid SHALL be 1; in BOOT and HALT it SHALL be 0.
REQ-028 RUN SHALL move to HALT on i_halt when no redirect is present.
REQ-029 HALT SHALL move to RUN on i_resume, with o_pc unchanged.
REQ-030 i_exc SHALL take effect in any state and force RUN.
REQ-031 Redirect priority SHALL be i_exc > i_ret > i_call > i_jump > i_branch; lower-priority requests in the same cycle are ignored.
REQ-032 A redirect in RUN or from i_exc SHALL load o_pc on the next edge, regardless of i_fetch_ready; the current fetch is cancelled.
REQ-033 Redirect targets: exc -> EXC_VEC; ret -> RAS top, or i_ret_fallback if the RAS is empty; call, jump, branch -> i_target.
REQ-034 Without a redirect, in RUN, o_fetch_valid && i_fetch_ready SHALL advance o_pc by INC on the next edge; otherwise o_pc holds.
REQ-035 The PC increment SHALL wrap modulo 2^PC_W with no flag.
REQ-036 A call SHALL push o_pc+INC (wrapped).
REQ-037 A call on a full RAS SHALL overwrite the oldest entry, keep the count at RAS_DEPTH, and pulse o_ras_overflow.
REQ-038 A ret SHALL pop one entry.
REQ-039 A ret on an empty RAS SHALL leave the count at 0 and pulse o_ras_underflow.
REQ-040 i_exc SHALL flush the RAS (count 0, no pulse).
REQ-041 Redirect inputs SHALL be ignored in BOOT and HALT, except i_exc.
REQ-042 o_ras_empty and o_ras_full SHALL be registered-state derived, with no combinational path from the redirect inputs.

Reset
REQ-043 Reset assertion SHALL immediately set o_pc=RESET_VEC, FSM=BOOT, RAS count=0, o_fetch_valid=0, and both RAS pulses=0, independent of i_clk.
REQ-044 Reset mid-operation SHALL discard in-flight redirects and the RAS contents.
REQ-045 RAS storage entries need not be reset.

Structure
REQ-046 Shared package pc_pkg SHALL hold the FSM state enum (BOOT, RUN, HALT) and the redirect-kind enum (NONE, EXC, RET, CALL, JUMP, BRANCH).
REQ-047 The RAS SHALL be sub-module pc_ras, a circular stack with push, pop, flush, top, empty, full, overflow and underflow, parametrised by PC_W and RAS_DEPTH.

Verification
REQ-048 Reset release, i_fetch_ready=1 -> cycle 1 o_fetch_valid=0, o_pc=0; then o_pc=0, 4, 8, ... one step per cycle.
REQ-049 i_fetch_ready=0 for 3 cycles at o_pc=0x0010 -> o_pc holds 0x0010, then advances to 0x0014 on the first ready cycle.
REQ-050 o_pc=0xFFFC with ready -> next o_pc=0x0000, no flag.
REQ-051 5 calls (RAS_DEPTH=4) from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> o_ras_overflow on the 5th; then 5 returns yield 0x54, 0x44, 0x34, 0x24, then i_ret_fallback with o_ras_underflow.
REQ-052 i_exc, i_ret and i_jump in the same cycle, RAS non-empty -> o_pc=0x0080, o_ras_empty=1.
REQ-053 i_halt, then i_exc while halted -> o_fetch_valid=0 during HALT, then o_pc=0x0080 and state RUN; reset asserted mid-run -> o_pc=0 immediately, without waiting for a clock edge.
